// File: rtl/accel_pkg.sv
// Shared definitions for the fixed-point dot-product accelerator:
// controller states, CSR word offsets and the default fraction width.
package accel_pkg;

    localparam int unsigned FRAC_BITS_DEFAULT = 16;

    localparam logic [3:0] CSR_CTRL  = 4'd0;
    localparam logic [3:0] CSR_WBASE = 4'd2;
    localparam logic [3:0] CSR_ABASE = 4'd3;
    localparam logic [3:0] CSR_LEN   = 4'd5;

    typedef enum logic [2:0] {
        IDLE,
        RD_W,
        WT_W,
        RD_A,
        WT_A,
        ACC,
        DONE
    } state_e;

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed fixed-point multiply-accumulate: acc_out = acc_in + (a*b >>> FRAC_BITS),
// keeping the low 32 bits of the shifted product and wrapping on overflow.
module fxp_mac
    import accel_pkg::*;
#(
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] acc_in,
    output logic [31:0] acc_out
);

    logic signed [63:0] product;

    always_comb begin
        product = 64'($signed(a)) * 64'($signed(b));
        acc_out = acc_in + 32'(product >>> FRAC_BITS);
    end

endmodule

// File: rtl/dot_accel.sv
// Dot-product accelerator: CSR slave programs two vector bases and a length,
// a read-only master fetches W[i]/A[i] pairs and fxp_mac accumulates the sum.
module dot_accel
    import accel_pkg::*;
#(
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);

    state_e      state_q, state_d;
    logic [31:0] wbase_q, wbase_d;
    logic [31:0] abase_q, abase_d;
    logic [31:0] len_q, len_d;
    logic [31:0] idx_q, idx_d;
    logic [31:0] w_q, w_d;
    logic [31:0] a_q, a_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic [31:0] mac_out;

    assign master_write     = 1'b0;
    assign master_writedata = '0;

    fxp_mac #(
        .FRAC_BITS(FRAC_BITS)
    ) u_mac (
        .a      (w_q),
        .b      (a_q),
        .acc_in (acc_q),
        .acc_out(mac_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wbase_q  <= '0;
            abase_q  <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            w_q      <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            wbase_q  <= wbase_d;
            abase_q  <= abase_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            w_q      <= w_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        wbase_d           = wbase_q;
        abase_d           = abase_q;
        len_d             = len_q;
        idx_d             = idx_q;
        w_d               = w_q;
        a_d               = a_q;
        acc_d             = acc_q;
        result_d          = result_q;
        slave_waitrequest = 1'b1;
        slave_readdata    = '0;
        master_read       = 1'b0;
        master_address    = '0;

        case (state_q)
            IDLE: begin
                // Only IDLE completes CSR accesses; every other state stalls them.
                slave_waitrequest = 1'b0;
                if (slave_read && slave_address == CSR_CTRL) begin
                    slave_readdata = result_q;
                end
                if (slave_write) begin
                    case (slave_address)
                        CSR_CTRL: begin
                            acc_d   = '0;
                            idx_d   = '0;
                            state_d = (len_q == '0) ? DONE : RD_W;
                        end
                        CSR_WBASE: wbase_d = slave_writedata;
                        CSR_ABASE: abase_d = slave_writedata;
                        CSR_LEN:   len_d   = slave_writedata;
                        default: ;
                    endcase
                end
            end
            RD_W: begin
                master_read    = 1'b1;
                master_address = word_addr(wbase_q, idx_q);
                if (!master_waitrequest) begin
                    state_d = WT_W;
                end
            end
            WT_W: begin
                if (master_readdatavalid) begin
                    w_d     = master_readdata;
                    state_d = RD_A;
                end
            end
            RD_A: begin
                master_read    = 1'b1;
                master_address = word_addr(abase_q, idx_q);
                if (!master_waitrequest) begin
                    state_d = WT_A;
                end
            end
            WT_A: begin
                if (master_readdatavalid) begin
                    a_d     = master_readdata;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d   = mac_out;
                idx_d   = idx_q + 32'd1;
                state_d = (idx_d < len_q) ? RD_W : DONE;
            end
            DONE: begin
                result_d = acc_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dot_accel.sv
// Scoreboarded bench for dot_accel: a behavioural memory answers master reads,
// stimulus queues expected addresses/readdata and a monitor checks them.
module tb_dot_accel;
    import accel_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    always #5 clk = ~clk;

    dot_accel #(.FRAC_BITS(16)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .slave_waitrequest   (slave_waitrequest),
        .slave_address       (slave_address),
        .slave_read          (slave_read),
        .slave_readdata      (slave_readdata),
        .slave_write         (slave_write),
        .slave_writedata     (slave_writedata),
        .master_waitrequest  (master_waitrequest),
        .master_address      (master_address),
        .master_read         (master_read),
        .master_readdata     (master_readdata),
        .master_readdatavalid(master_readdatavalid),
        .master_write        (master_write),
        .master_writedata    (master_writedata)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_rd_q[$];

    int stall_cfg = 0;
    int lat_cfg   = 0;
    int spur_en   = 0;
    int stall_cnt = 0;
    int lat_cnt   = 0;
    int accepts   = 0;
    int outstanding = 0;
    logic pending = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] pend_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0100: mem_word = 32'h0001_0000;
            32'h0000_0104: mem_word = 32'h0002_0000;
            32'h0000_0108: mem_word = 32'hFFFF_8000;
            32'h0000_0200: mem_word = 32'h0003_0000;
            32'h0000_0204: mem_word = 32'h0000_8000;
            32'h0000_0208: mem_word = 32'h0004_0000;
            32'h0000_0300: mem_word = 32'hFFFE_0000;
            32'h0000_0304: mem_word = 32'h0001_8000;
            32'h0000_0400: mem_word = 32'h0002_8000;
            32'h0000_0404: mem_word = 32'hFFFF_0000;
            32'hFFFF_FFFC: mem_word = 32'h0001_0000;
            32'h0000_0000: mem_word = 32'h0003_0000;
            32'h0000_0500: mem_word = 32'h0005_0000;
            32'h0000_0504: mem_word = 32'h0002_0000;
            32'h0000_0600: mem_word = 32'h7FFF_0000;
            32'h0000_0604: mem_word = 32'h0000_0001;
            32'h0000_0700: mem_word = 32'h0002_0000;
            32'h0000_0704: mem_word = 32'hFFFF_FFFF;
            default:       mem_word = 32'h0BAD_0BAD;
        endcase
    endfunction

    // Memory slave: optional waitrequest stall, fixed read latency, and an
    // optional bogus readdatavalid while a request is being stalled.
    always @(negedge clk) begin
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
        if (!rst_n) begin
            pending            = 1'b0;
            stall_cnt          = 0;
            master_waitrequest = 1'b0;
        end else begin
            if (pending) begin
                if (lat_cnt == 0) begin
                    master_readdatavalid = 1'b1;
                    master_readdata      = pend_data;
                    pending              = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end
            master_waitrequest = 1'b0;
            if (master_read) begin
                if (stall_cnt < stall_cfg) begin
                    master_waitrequest = 1'b1;
                    stall_cnt++;
                    if (spur_en != 0 && !master_readdatavalid) begin
                        master_readdatavalid = 1'b1;
                        master_readdata      = 32'hDEAD_BEEF;
                    end
                end else begin
                    stall_cnt = 0;
                    pending   = 1'b1;
                    lat_cnt   = lat_cfg;
                    pend_data = mem_word(master_address);
                end
            end
        end
    end

    // Monitor: compares each master request and each completed CSR read
    // against the queued expectations.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            outstanding = 0;
            prev_stall  = 1'b0;
        end else begin
            if (prev_stall) check("read_held_in_stall", {31'b0, master_read}, 32'd1);
            prev_stall = master_read && master_waitrequest;
            if (master_read) begin
                check("no_request_while_outstanding", 32'(outstanding), 32'd0);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_master_read actual=%h expected=none", master_address);
                end else begin
                    check("master_address", master_address, exp_addr_q[0]);
                    if (!master_waitrequest) void'(exp_addr_q.pop_front());
                end
                if (!master_waitrequest) begin
                    outstanding++;
                    accepts++;
                end
            end
            if (master_readdatavalid && !master_read && outstanding > 0) outstanding--;
            if (slave_read && !slave_waitrequest) begin
                if (exp_rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_csr_read actual=%h expected=none", slave_readdata);
                end else begin
                    check("csr_readdata", slave_readdata, exp_rd_q.pop_front());
                end
            end
        end
    end

    task automatic csr_write(input logic [3:0] addr, input logic [31:0] data, input bit expect_nowait);
        int waits;
        waits = 0;
        @(negedge clk);
        slave_address   = addr;
        slave_writedata = data;
        slave_write     = 1'b1;
        #1;
        while (slave_waitrequest && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 200) begin
            checks++;
            errors++;
            $display("FAIL csr_write_timeout actual=%0d expected=<200", waits);
        end
        if (expect_nowait) check("csr_write_no_wait", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] addr, input logic [31:0] exp, output int waits);
        exp_rd_q.push_back(exp);
        waits = 0;
        @(negedge clk);
        slave_address = addr;
        slave_read    = 1'b1;
        #1;
        while (slave_waitrequest && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 200) begin
            checks++;
            errors++;
            $display("FAIL csr_read_timeout actual=%0d expected=<200", waits);
        end
        @(posedge clk);
        #1;
        slave_read = 1'b0;
    endtask

    task automatic program_job(input logic [31:0] wb, input logic [31:0] ab, input int n);
        csr_write(CSR_WBASE, wb, 1'b1);
        csr_write(CSR_ABASE, ab, 1'b1);
        csr_write(CSR_LEN, 32'(n), 1'b1);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(wb + 32'(4 * i));
            exp_addr_q.push_back(ab + 32'(4 * i));
        end
    endtask

    task automatic run_job(input logic [31:0] wb, input logic [31:0] ab, input int n,
                           input logic [31:0] expected);
        int waits;
        program_job(wb, ab, n);
        csr_write(CSR_CTRL, 32'd1, 1'b1);
        csr_read(CSR_CTRL, expected, waits);
        check("read_stalled_while_busy", {31'b0, waits > 0}, 32'd1);
        check("all_reads_issued", 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        int waits;
        int cycles;
        int base;
        rst_n           = 1'b0;
        slave_address   = '0;
        slave_read      = 1'b0;
        slave_write     = 1'b0;
        slave_writedata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_slave_waitrequest", {31'b0, slave_waitrequest}, 32'd0);
        check("reset_master_read", {31'b0, master_read}, 32'd0);
        check("reset_master_write", {31'b0, master_write}, 32'd0);
        check("reset_master_writedata", master_writedata, 32'd0);
        rst_n = 1'b1;

        csr_read(CSR_CTRL, 32'd0, waits);
        csr_write(CSR_WBASE, 32'h0000_1234, 1'b1);
        csr_read(CSR_WBASE, 32'd0, waits);

        // 1.0*3.0 + 2.0*0.5 + (-0.5)*4.0 = 2.0
        run_job(32'h0000_0100, 32'h0000_0200, 3, 32'h0002_0000);

        csr_write(CSR_LEN, 32'd0, 1'b1);
        csr_write(CSR_CTRL, 32'd1, 1'b1);
        cycles = 1;
        while (slave_waitrequest && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("len0_idle_within_2", {31'b0, cycles <= 2}, 32'd1);
        csr_read(CSR_CTRL, 32'd0, waits);

        // -2.0*2.5 + 1.5*(-1.0) = -6.5, with stalled requests and bogus valids
        stall_cfg = 4;
        spur_en   = 1;
        run_job(32'h0000_0300, 32'h0000_0400, 2, 32'hFFF9_8000);
        stall_cfg = 0;
        spur_en   = 0;

        // Weight base wraps past 2^32: 1.0*5.0 + 3.0*2.0 = 11.0, slow data
        lat_cfg = 5;
        run_job(32'hFFFF_FFFC, 32'h0000_0500, 2, 32'h000B_0000);
        lat_cfg = 0;

        // Truncated product 0xFFFE0000 plus floor(-1/65536) = -1
        run_job(32'h0000_0600, 32'h0000_0700, 2, 32'hFFFD_FFFF);

        lat_cfg = 20;
        program_job(32'h0000_0100, 32'h0000_0200, 3);
        base = accepts;
        csr_write(CSR_CTRL, 32'd1, 1'b1);
        cycles = 0;
        while (accepts < base + 2 && cycles < 200) begin
            @(negedge clk);
            #3;
            cycles++;
        end
        check("reached_wt_a", {31'b0, cycles < 200}, 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_master_read", {31'b0, master_read}, 32'd0);
        check("midrun_reset_idle", {31'b0, slave_waitrequest}, 32'd0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        exp_addr_q.delete();
        lat_cfg = 0;
        csr_read(CSR_CTRL, 32'd0, waits);
        run_job(32'h0000_0100, 32'h0000_0200, 3, 32'h0002_0000);

        repeat (3) @(negedge clk);
        check("csr_reads_consumed", 32'(exp_rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dot_accel.md
DOT_ACCEL -- requirements
Module: dot_accel

Interface
REQ-001 Parameter FRAC_BITS, default 16: fraction bits of signed fixed-point operands and result.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low. Clock port is clk and reset port is rst_n.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 slave_waitrequest  out  1  stalls a CSR access while the block is busy.
REQ-006 slave_address  in  4  CSR word offset.
REQ-007 slave_read  in  1  CSR read strobe.
REQ-008 slave_readdata  out  32  CSR read data.
REQ-009 slave_write  in  1  CSR write strobe.
REQ-010 slave_writedata  in  32  CSR write data.
REQ-011 master_waitrequest  in  1  memory stall; a request completes only in a cycle where this is low.
REQ-012 master_address  out  32  byte address of the memory read.
REQ-013 master_read  out  1  memory read request.
REQ-014 master_readdata  in  32  memory read data.
REQ-015 master_readdatavalid  in  1  master_readdata is valid this cycle.
REQ-016 master_write  out  1  tied 0; the block never writes memory.
REQ-017 master_writedata  out  32  tied 0.

Function
REQ-018 CSR map: offset 2 = weight base address, 3 = activation base address, 5 = vector length N (words). Writes to these offsets SHALL be accepted in IDLE with zero wait.
REQ-019 A write to offset 0 in IDLE SHALL start a dot product: result = sum over i<N of (W[i]*A[i]) >>> FRAC_BITS.
REQ-020 States SHALL be IDLE, RD_W, WT_W, RD_A, WT_A, ACC, DONE.
REQ-021 IDLE->RD_W on start with N!=0; with N==0, IDLE->DONE, result 0, no master request.
REQ-022 RD_W SHALL drive master_read=1 and master_address=wbase+4*i, held stable until master_waitrequest=0, then go to WT_W.
REQ-023 WT_W SHALL capture master_readdata when master_readdatavalid=1 and go to RD_A; readdatavalid in any other state SHALL be ignored.
REQ-024 RD_A/WT_A SHALL mirror RD_W/WT_W using abase+4*i.
REQ-025 ACC SHALL form the signed 32x32->64 product, add bits [FRAC_BITS+31:FRAC_BITS] to a 32-bit accumulator with two's-complement wrap, increment i, go to RD_W if i+1<N, else DONE.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32.
REQ-027 DONE SHALL go to IDLE in one cycle; the result register SHALL hold until the next start.
REQ-028 slave_waitrequest SHALL be 1 in every state except IDLE; a CSR access presented while busy stalls until IDLE.
REQ-029 Slave read of offset 0 in IDLE SHALL return the last result; reads of other offsets SHALL return 0.
REQ-030 Base and length registers SHALL NOT change while busy.
REQ-031 A start write while busy SHALL be stalled, not queued, and accepted once IDLE.

Reset
REQ-032 Asserting rst_n=0 at any time, including mid-transaction, SHALL force IDLE, master_read=0, slave_waitrequest=0, and clear result, accumulator, index, bases and N to 0.

Structure
REQ-033 State enum, CSR offset constants and FRAC_BITS default SHALL live in shared package accel_pkg.
REQ-034 The multiply-accumulate SHALL be a sub-module fxp_mac (signed product, shift, wrapping add).

Verification
REQ-035 wbase=0x100, abase=0x200, N=3, W=[0x00010000,0x00020000,0xFFFF8000], A=[0x00030000,0x00008000,0x00040000] -> read offset 0 returns 0x00020000.
REQ-036 N=0, then start -> no master_read pulse; slave_waitrequest low again within 2 cycles; result 0.
REQ-037 master_waitrequest held high 4 cycles during RD_W -> master_read and master_address stay stable for all 4 cycles; one read issued.
REQ-038 readdatavalid delayed 5 cycles after accept -> no new request issued in the meantime; the result still matches the reference value.
REQ-039 Slave read of offset 0 issued right after start -> slave_waitrequest stays high until DONE, then returns the final sum.
REQ-040 rst_n pulsed low during WT_A -> master_read=0 and the block is in IDLE; a fresh start yields the correct result.
